// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller between video (p0), CPU (p1) and loader (p2),
// one access per 8-phase clkref-aligned slot, with forced idle slots for auto-refresh.
module sdram_port_arbiter #(
    parameter int REFRESH_INTERVAL = 48,
    parameter int SLOT_LAST = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkref,
    input  logic        p0_req,
    input  logic [23:0] p0_addr,
    output logic [15:0] p0_rdata,
    output logic        p0_ack,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [23:0] p1_addr,
    input  logic [1:0]  p1_ds,
    input  logic [15:0] p1_wdata,
    output logic [15:0] p1_rdata,
    output logic        p1_ack,
    input  logic        p2_req,
    input  logic        p2_we,
    input  logic [23:0] p2_addr,
    input  logic [1:0]  p2_ds,
    input  logic [15:0] p2_wdata,
    output logic [15:0] p2_rdata,
    output logic        p2_ack,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    output logic [1:0]  mem_ds,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [1:0]  grant_id
);
    logic [2:0]  phase;
    logic        last_clkref;
    logic [7:0]  busy_cnt;
    logic [1:0]  rr_ptr;
    logic        e0, e1, e2, boundary;
    logic [1:0]  next_id;
    logic [23:0] sel_addr;
    logic [15:0] sel_din;
    logic [1:0]  sel_ds;
    logic        sel_we;

    // the port completing this slot still holds req, so it sits out this arbitration
    always_comb begin
        boundary = phase == 3'(SLOT_LAST);
        e0 = p0_req & (grant_id != 2'd0);
        e1 = p1_req & (grant_id != 2'd1);
        e2 = p2_req & (grant_id != 2'd2);
        next_id = (busy_cnt == 8'(REFRESH_INTERVAL - 1)) ? 2'd3 :
                  e0 ? 2'd0 : (e1 & e2) ? rr_ptr : e1 ? 2'd1 : e2 ? 2'd2 : 2'd3;
        sel_addr = (next_id == 2'd0) ? p0_addr : (next_id == 2'd1) ? p1_addr : p2_addr;
        sel_din = (next_id == 2'd0) ? 16'd0 : (next_id == 2'd1) ? p1_wdata : p2_wdata;
        sel_ds = (next_id == 2'd0) ? 2'b11 : (next_id == 2'd1) ? p1_ds : p2_ds;
        sel_we = (next_id == 2'd1) ? p1_we : (next_id == 2'd2) ? p2_we : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= 3'd0;
            last_clkref <= 1'b0;
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            p2_ack <= 1'b0;
            p0_rdata <= 16'd0;
            p1_rdata <= 16'd0;
            p2_rdata <= 16'd0;
            mem_oe <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= 24'd0;
            mem_din <= 16'd0;
            mem_ds <= 2'd0;
            grant_id <= 2'd3;
            busy_cnt <= 8'd0;
            rr_ptr <= 2'd1;
        end else begin
            last_clkref <= clkref;
            phase <= (clkref & ~last_clkref) ? 3'd0 : phase + 3'd1;
            p0_ack <= boundary && grant_id == 2'd0;
            p1_ack <= boundary && grant_id == 2'd1;
            p2_ack <= boundary && grant_id == 2'd2;
            if (boundary) begin
                p0_rdata <= (mem_oe && grant_id == 2'd0) ? mem_dout : p0_rdata;
                p1_rdata <= (mem_oe && grant_id == 2'd1) ? mem_dout : p1_rdata;
                p2_rdata <= (mem_oe && grant_id == 2'd2) ? mem_dout : p2_rdata;
                grant_id <= next_id;
                busy_cnt <= (next_id == 2'd3) ? 8'd0 : busy_cnt + 8'd1;
                mem_oe <= (next_id != 2'd3) & ~sel_we;
                mem_we <= (next_id != 2'd3) & sel_we;
                if (next_id != 2'd3) begin
                    mem_addr <= sel_addr;
                    mem_din <= sel_din;
                    mem_ds <= sel_ds;
                end
                if (next_id == 2'd1 || next_id == 2'd2)
                    rr_ptr <= 2'd3 - next_id;
            end
        end
    end
endmodule
